// File: rtl/moore_mod_counter_if.sv
// rtl/moore_mod_counter_if.sv - control/status bundle for moore_mod_counter (dir present only with MOORE_CNT_DOWN_EN)
interface moore_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef MOORE_CNT_DOWN_EN
  logic             dir;
`endif
  logic [WIDTH-1:0] count;
  logic             out;
  logic             wrap;
  logic             done;

`ifdef MOORE_CNT_DOWN_EN
  modport master (output en, clr, load, load_val, dir, input count, out, wrap, done);
  modport slave  (input en, clr, load, load_val, dir, output count, out, wrap, done);
`else
  modport master (output en, clr, load, load_val, input count, out, wrap, done);
  modport slave  (input en, clr, load, load_val, output count, out, wrap, done);
`endif
endinterface

// File: rtl/moore_mod_counter.sv
// rtl/moore_mod_counter.sv - Moore modulo counter FSM with clear/load/wrap/one-shot halt; MOORE_CNT_DOWN_EN adds dir
module moore_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int MATCH_VAL = 2,
  parameter int ONE_SHOT  = 0
) (
  input logic              clk,
  input logic              reset_n,
  moore_mod_counter_if.slave bus
);

  // Reject parameter sets that would let count leave 0..MODULO-1 or never match.
  if (MODULO < 2 || MODULO > (1 << WIDTH) || MATCH_VAL < 0 || MATCH_VAL >= MODULO) begin : g_bad_params
    $error("moore_mod_counter: illegal WIDTH/MODULO/MATCH_VAL combination");
  end

  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] MATCH   = WIDTH'(MATCH_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             down;
  logic [WIDTH-1:0] load_clamped;

`ifdef MOORE_CNT_DOWN_EN
  assign down = bus.dir;
`else
  assign down = 1'b0;
`endif

  // Out-of-range load values saturate at the terminal count.
  assign load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : TERM;

  // Outputs are pure decodes of registered state; no input reaches them.
  assign bus.count = count;
  assign bus.wrap  = wrap;
  assign bus.done  = (state == HALT);
  assign bus.out   = (count == MATCH);

  // Count/halt FSM: clr beats load beats en; wrap is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
      state <= RUN;
    end else begin
      wrap <= 1'b0;
      if (bus.clr) begin
        count <= '0;
        state <= RUN;
      end else if (bus.load) begin
        count <= load_clamped;
        state <= RUN;
      end else if (bus.en && state == RUN) begin
        if (down) begin
          if (count == '0) begin
            if (ONE_SHOT != 0) begin
              state <= HALT;
            end else begin
              count <= TERM;
              wrap  <= 1'b1;
            end
          end else begin
            count <= count - 1'b1;
          end
        end else begin
          if (count == TERM) begin
            if (ONE_SHOT != 0) begin
              state <= HALT;
            end else begin
              count <= '0;
              wrap  <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_moore_mod_counter.sv
// tb/tb_moore_mod_counter.sv - directed bench for moore_mod_counter (down-count section under MOORE_CNT_DOWN_EN)
module tb_moore_mod_counter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: MODULO=4 free-running; b: MODULO=10; c: MODULO=4 one-shot
  moore_mod_counter_if #(.WIDTH(4)) a_if ();
  moore_mod_counter_if #(.WIDTH(4)) b_if ();
  moore_mod_counter_if #(.WIDTH(4)) c_if ();

  moore_mod_counter #(.WIDTH(4), .MODULO(4), .MATCH_VAL(2), .ONE_SHOT(0))
    u_a (.clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  moore_mod_counter #(.WIDTH(4), .MODULO(10), .MATCH_VAL(2), .ONE_SHOT(0))
    u_b (.clk(clk), .reset_n(reset_n), .bus(b_if.slave));
  moore_mod_counter #(.WIDTH(4), .MODULO(4), .MATCH_VAL(2), .ONE_SHOT(1))
    u_c (.clk(clk), .reset_n(reset_n), .bus(c_if.slave));

`ifdef MOORE_CNT_DOWN_EN
  moore_mod_counter_if #(.WIDTH(4)) d_if ();
  moore_mod_counter #(.WIDTH(4), .MODULO(4), .MATCH_VAL(2), .ONE_SHOT(0))
    u_d (.clk(clk), .reset_n(reset_n), .bus(d_if.slave));
`endif

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       out;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic l, input logic e, input logic [3:0] lv,
                     input logic [3:0] cnt, input logic o, input logic w);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.load_val = lv;
    v.count = cnt; v.out = o; v.wrap = w;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c_exp_count[5];
    int c_exp_done[5];

    reset_n = 1'b0;
    a_if.en = 1'b0; a_if.clr = 1'b0; a_if.load = 1'b0; a_if.load_val = 4'd0;
    b_if.en = 1'b0; b_if.clr = 1'b0; b_if.load = 1'b0; b_if.load_val = 4'd0;
    c_if.en = 1'b0; c_if.clr = 1'b0; c_if.load = 1'b0; c_if.load_val = 4'd0;
`ifdef MOORE_CNT_DOWN_EN
    a_if.dir = 1'b0; b_if.dir = 1'b0; c_if.dir = 1'b0;
    d_if.en = 1'b0; d_if.clr = 1'b0; d_if.load = 1'b0; d_if.load_val = 4'd0; d_if.dir = 1'b0;
`endif

    //       clr   load  en    lv     count  out   wrap
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd7, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);

    // Reset state
    #12;
    check("reset.count", 32'(a_if.count), 32'd0);
    check("reset.out",   32'(a_if.out),   32'd0);
    check("reset.wrap",  32'(a_if.wrap),  32'd0);
    check("reset.done",  32'(c_if.done),  32'd0);
    reset_n = 1'b1;
    #2;

    // Free-running MODULO=4 table
    for (int i = 0; i < tbl.size(); i++) begin
      a_if.clr = tbl[i].clr; a_if.load = tbl[i].load;
      a_if.en = tbl[i].en; a_if.load_val = tbl[i].load_val;
      tick();
      check($sformatf("vec%0d.count", i), 32'(a_if.count), 32'(tbl[i].count));
      check($sformatf("vec%0d.out", i),   32'(a_if.out),   32'(tbl[i].out));
      check($sformatf("vec%0d.wrap", i),  32'(a_if.wrap),  32'(tbl[i].wrap));
      check($sformatf("vec%0d.done", i),  32'(a_if.done),  32'd0);
    end
    a_if.en = 1'b0; a_if.clr = 1'b0; a_if.load = 1'b0;

    // MODULO=10: load 13 clamps to 9, then wraps to 0
    b_if.load = 1'b1; b_if.load_val = 4'd13;
    tick();
    check("b.clamp.count", 32'(b_if.count), 32'd9);
    b_if.load = 1'b0; b_if.en = 1'b1;
    tick();
    check("b.wrap.count", 32'(b_if.count), 32'd0);
    check("b.wrap.wrap",  32'(b_if.wrap),  32'd1);
    tick();
    check("b.after.count", 32'(b_if.count), 32'd1);
    check("b.after.wrap",  32'(b_if.wrap),  32'd0);

    // clr beats load and en at count 5
    b_if.en = 1'b0; b_if.load = 1'b1; b_if.load_val = 4'd5;
    tick();
    check("b.load5.count", 32'(b_if.count), 32'd5);
    b_if.clr = 1'b1; b_if.load = 1'b1; b_if.en = 1'b1; b_if.load_val = 4'd7;
    tick();
    check("b.clrprio.count", 32'(b_if.count), 32'd0);
    check("b.clrprio.wrap",  32'(b_if.wrap),  32'd0);
    b_if.clr = 1'b0; b_if.load = 1'b0; b_if.en = 1'b0;

    // One-shot: 1,2,3 then halt at 3 with done, never wrap
    c_exp_count = '{1, 2, 3, 3, 3};
    c_exp_done  = '{0, 0, 0, 1, 1};
    c_if.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("c.step%0d.count", i), 32'(c_if.count), 32'(c_exp_count[i]));
      check($sformatf("c.step%0d.done", i),  32'(c_if.done),  32'(c_exp_done[i]));
      check($sformatf("c.step%0d.wrap", i),  32'(c_if.wrap),  32'd0);
    end
    c_if.load = 1'b1; c_if.load_val = 4'd1;
    tick();
    check("c.reload.count", 32'(c_if.count), 32'd1);
    check("c.reload.done",  32'(c_if.done),  32'd0);
    c_if.load = 1'b0;
    tick();
    check("c.resume.count", 32'(c_if.count), 32'd2);
    tick();
    tick();
    check("c.rehalt.done", 32'(c_if.done), 32'd1);
    c_if.clr = 1'b1;
    tick();
    check("c.clr.count", 32'(c_if.count), 32'd0);
    check("c.clr.done",  32'(c_if.done),  32'd0);
    c_if.clr = 1'b0; c_if.en = 1'b0;

`ifdef MOORE_CNT_DOWN_EN
    // Down count 3,2,1,0,3,2 then flip to up at 2 -> 3
    d_if.dir = 1'b1; d_if.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("d.step%0d.count", i), 32'(d_if.count), 32'((7 - i) % 4));
      check($sformatf("d.step%0d.wrap", i),  32'(d_if.wrap),  32'((i == 0 || i == 4) ? 1 : 0));
    end
    d_if.dir = 1'b0;
    tick();
    check("d.flip.count", 32'(d_if.count), 32'd3);
    check("d.flip.wrap",  32'(d_if.wrap),  32'd0);
    d_if.en = 1'b0;
`endif

    // Async reset mid-cycle at count 3
    a_if.load = 1'b1; a_if.load_val = 4'd3;
    tick();
    a_if.load = 1'b0;
    check("rst.pre.count", 32'(a_if.count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst.async.count", 32'(a_if.count), 32'd0);
    check("rst.async.wrap",  32'(a_if.wrap),  32'd0);
    #1;
    reset_n = 1'b1;
    a_if.en = 1'b1;
    tick();
    check("rst.resume.count", 32'(a_if.count), 32'd1);
    a_if.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
